pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the RISC core. It holds the PC register and selects the next PC from four sources: sequential, constant target, jump-register, and return. It adds a small hardware return-address stack (RAS) for call/return, plus stall support. It sits at the front of the fetch stage, feeds instruction memory and the PC+4 adder path, and replaces the purely combinational next-PC select.

## Interface
Parameters:
- PC_W, 5, PC width in bits; all PC arithmetic is modulo 2^PC_W
- RESET_PC, 0, PC value loaded on reset (PC_W bits)
- RAS_DEPTH, 4, return-address stack entries (≥2, power of two)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and RAS this cycle
- pcsel  in  2  next-PC source: 00 seq, 01 const, 10 jump-register, 11 return
- pc_const  in  PC_W  precomputed branch/jump target
- rd1  in  32  register-file read data; bits [PC_W-1:0] form the jump-register target
- call  in  1  push return address (current pc_plus_4) when the update is accepted
- pc  out  PC_W  current PC (registered)
- pc_plus_4  out  PC_W  pc + 4, wrapping modulo 2^PC_W (combinational from pc)
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_err  out  1  one-cycle pulse: return was taken on an empty RAS

## Operation
- Update is accepted on a rising clk edge with rst=0 and stall=0.
- Next-PC selection by pcsel:
  - 00: pc_plus_4
  - 01: pc_const
  - 10: rd1[PC_W-1:0]
  - 11: RAS top. If the RAS is empty, the next PC is pc_plus_4 and ras_err is set for the following cycle.
- RAS is circular, with a top pointer and an occupancy count (0..RAS_DEPTH).
  - Pop (pcsel=11, accepted, not empty): count−1, pointer−1.
  - Push (call=1, accepted): writes pc_plus_4 of the current cycle. Pointer+1.
  - Push when full: overwrites the oldest entry. Count stays at RAS_DEPTH, ras_full stays 1.
- call=1 with pcsel=11 in the same cycle:
  - The next PC is the old top.
  - The top entry is replaced by pc_plus_4, and the count is unchanged.
  - If the RAS was empty: the next PC is pc_plus_4, ras_err pulses, and the push occurs (count becomes 1).
- call=1 with pcsel 00/01/10: the PC updates per pcsel and the push occurs.
- Stall: pc, the RAS contents, pointer and count all hold. ras_err is driven 0. call and pcsel are ignored.
- Reset (any cycle, including mid-call or mid-stall):
  - pc=RESET_PC, count=0, pointer=0
  - ras_empty=1, ras_full=0, ras_err=0
  - RAS entry contents are don't-care.
- ras_empty = (count==0) and ras_full = (count==RAS_DEPTH), both decoded from the registered count.

## Timing
- The new PC is visible on pc one cycle after the accepting edge. pc_plus_4 follows pc combinationally within the same cycle.
- A return in cycle N reads the RAS top as of cycle N, so a push in N−1 is visible to a pop in N (back-to-back call→return works).
- ras_err is registered: it is high exactly the one cycle after the offending edge.
- No combinational path from rd1/pc_const/pcsel to pc. Only pc_plus_4 and the flags are outputs of registered state.
- While stall=1, all outputs are stable. Removing stall takes effect at the next edge.

## Structure
- Shared package pc_pkg:
  - pcsel encodings PCSEL_SEQ=2'b00, PCSEL_CONST=2'b01, PCSEL_JR=2'b10, PCSEL_RET=2'b11
  - PC increment constant PC_INC=4
- Sub-module pc_ras, the circular return-address stack:
  - parameters PC_W and RAS_DEPTH
  - inputs push, pop, push_data
  - outputs top, empty, full
- pc_unit contains the PC register, the next-PC mux, the ras_err register and one pc_ras instance.

## Test plan
All scenarios use PC_W=5, RAS_DEPTH=4, RESET_PC=0.
- Reset then pcsel=00 for 9 cycles → pc 0,4,8,…,28,0 (wrap). pc_plus_4=0 while pc=28.
- pcsel=01, pc_const=20 → pc=20 next cycle. Then pcsel=10, rd1=32'hFFFF_FF09 → pc=9.
- Call/return: at pc=8, call=1 with pcsel=01 and pc_const=24 → pc=24, ras_empty=0. Then pcsel=11 → pc=12 and ras_empty=1.
- Overflow: five consecutive calls from pcs 0,4,8,12,16 (each call is pcsel=00, call=1, so the pushed values are 4,8,12,16,20) → ras_full=1 after the 4th. Four pops then return 20,16,12,8; the entry 4 was overwritten, and ras_empty=1.
- Pop on empty at pc=16 → pc=20, ras_err=1 for exactly one cycle. Simultaneous call+return with top=12 at pc=4 → pc=12, top becomes 8, count unchanged.
- stall=1 for 3 cycles with pcsel=01 and call=1 → pc and the RAS flags are unchanged. rst asserted during stall → pc=0, ras_empty=1 on the next cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings and constants for the program-counter unit.
package pc_pkg;
  localparam logic [1:0] PCSEL_SEQ   = 2'b00;
  localparam logic [1:0] PCSEL_CONST = 2'b01;
  localparam logic [1:0] PCSEL_JR    = 2'b10;
  localparam logic [1:0] PCSEL_RET   = 2'b11;
  localparam int         PC_INC      = 4;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; on overflow the oldest entry is overwritten.
module pc_ras #(
  parameter int PC_W      = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_pop;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_W'(RAS_DEPTH));
  assign top    = mem[ptr];
  assign do_pop = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !do_pop) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) cnt <= cnt + CNT_W'(1);
    end else if (do_pop && !push) begin
      ptr <= ptr - PTR_W'(1);
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Push+pop together replaces the top in place; entries need no reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      if (do_pop) mem[ptr] <= push_data;
      else        mem[ptr + PTR_W'(1)] <= push_data;
    end
  end
endmodule

// File: rtl/pc_unit.sv
// PC register with four-way next-PC select, return-address stack and stall.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = 5,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      pcsel,
  input  logic [PC_W-1:0] pc_const,
  input  logic [31:0]     rd1,
  input  logic            call,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus_4,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] ras_top;
  logic            is_ret;
  logic            rd1_unused;

  assign rd1_unused = ^rd1[31:PC_W];
  assign pc_plus_4  = pc + PC_W'(PC_INC);
  assign is_ret     = (pcsel == PCSEL_RET);

  always_comb begin
    next_pc = pc_plus_4;
    unique case (pcsel)
      PCSEL_SEQ:   next_pc = pc_plus_4;
      PCSEL_CONST: next_pc = pc_const;
      PCSEL_JR:    next_pc = rd1[PC_W-1:0];
      PCSEL_RET:   next_pc = ras_empty ? pc_plus_4 : ras_top;
      default:     next_pc = pc_plus_4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ras_err <= 1'b0;
    end else begin
      if (!stall) pc <= next_pc;
      ras_err <= ~stall & is_ret & ras_empty;
    end
  end

  pc_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (call & ~stall),
    .pop       (is_ret & ~stall),
    .push_data (pc_plus_4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit (PC_W=5, RAS_DEPTH=4, RESET_PC=0).
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pcsel = 2'b00;
  logic [4:0]  pc_const = '0;
  logic [31:0] rd1 = '0;
  logic        call = 1'b0;
  logic [4:0]  pc, pc_plus_4;
  logic        ras_empty, ras_full, ras_err;

  typedef struct {
    logic [4:0] pc;
    logic [4:0] pc4;
    logic       empty;
    logic       full;
    logic       err;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_unit #(.PC_W(5), .RESET_PC(5'd0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pcsel(pcsel), .pc_const(pc_const),
    .rd1(rd1), .call(call), .pc(pc), .pc_plus_4(pc_plus_4),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the state expected after that edge.
  task automatic step(input logic r, input logic s, input logic [1:0] sel,
                      input logic [4:0] cst, input logic [31:0] r1, input logic c,
                      input logic [4:0] e_pc, input logic e_empty, input logic e_full,
                      input logic e_err, input string name);
    exp_t e;
    rst = r; stall = s; pcsel = sel; pc_const = cst; rd1 = r1; call = c;
    @(posedge clk);
    #1;
    e.pc = e_pc; e.pc4 = e_pc + 5'd4; e.empty = e_empty; e.full = e_full;
    e.err = e_err; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compares registered state mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || pc_plus_4 !== e.pc4 || ras_empty !== e.empty ||
          ras_full !== e.full || ras_err !== e.err) begin
        errors++;
        $display("FAIL %s: got pc=%0d pc4=%0d empty=%b full=%b err=%b, want pc=%0d pc4=%0d empty=%b full=%b err=%b",
                 e.name, pc, pc_plus_4, ras_empty, ras_full, ras_err,
                 e.pc, e.pc4, e.empty, e.full, e.err);
      end
    end
  end

  initial begin
    @(negedge clk);
    step(1, 0, 2'b00, 0, 0, 0, 5'd0, 1, 0, 0, "reset");
    // Sequential run with wrap at 28 -> 0
    for (int i = 1; i <= 9; i++)
      step(0, 0, 2'b00, 0, 0, 0, 5'((i * 4) % 32), 1, 0, 0, "seq");
    step(0, 0, 2'b01, 5'd20, 0, 0, 5'd20, 1, 0, 0, "const20");
    step(0, 0, 2'b10, 0, 32'hFFFF_FF09, 0, 5'd9, 1, 0, 0, "jr9");
    // Call then return
    step(0, 0, 2'b01, 5'd8, 0, 0, 5'd8, 1, 0, 0, "const8");
    step(0, 0, 2'b01, 5'd24, 0, 1, 5'd24, 0, 0, 0, "call_to24");
    step(0, 0, 2'b11, 0, 0, 0, 5'd12, 1, 0, 0, "ret12");
    // Overflow: five pushes 4,8,12,16,20; oldest (4) is lost
    step(0, 0, 2'b01, 5'd0, 0, 0, 5'd0, 1, 0, 0, "const0");
    step(0, 0, 2'b00, 0, 0, 1, 5'd4, 0, 0, 0, "push4");
    step(0, 0, 2'b00, 0, 0, 1, 5'd8, 0, 0, 0, "push8");
    step(0, 0, 2'b00, 0, 0, 1, 5'd12, 0, 0, 0, "push12");
    step(0, 0, 2'b00, 0, 0, 1, 5'd16, 0, 1, 0, "push16_full");
    step(0, 0, 2'b00, 0, 0, 1, 5'd20, 0, 1, 0, "push20_ovf");
    step(0, 0, 2'b11, 0, 0, 0, 5'd20, 0, 0, 0, "pop20");
    step(0, 0, 2'b11, 0, 0, 0, 5'd16, 0, 0, 0, "pop16");
    step(0, 0, 2'b11, 0, 0, 0, 5'd12, 0, 0, 0, "pop12");
    step(0, 0, 2'b11, 0, 0, 0, 5'd8, 1, 0, 0, "pop8_empty");
    // Return on empty stack
    step(0, 0, 2'b01, 5'd16, 0, 0, 5'd16, 1, 0, 0, "const16");
    step(0, 0, 2'b11, 0, 0, 0, 5'd20, 1, 0, 1, "ret_empty_err");
    step(0, 0, 2'b00, 0, 0, 0, 5'd24, 1, 0, 0, "err_cleared");
    // Simultaneous call+return replaces the top
    step(0, 0, 2'b01, 5'd8, 0, 0, 5'd8, 1, 0, 0, "const8b");
    step(0, 0, 2'b00, 0, 0, 1, 5'd12, 0, 0, 0, "push12b");
    step(0, 0, 2'b01, 5'd4, 0, 0, 5'd4, 0, 0, 0, "const4");
    step(0, 0, 2'b11, 0, 0, 1, 5'd12, 0, 0, 0, "callret");
    step(0, 0, 2'b11, 0, 0, 0, 5'd8, 1, 0, 0, "ret_new_top8");
    // Simultaneous call+return on empty: err pulse, push happens
    step(0, 0, 2'b11, 0, 0, 1, 5'd12, 0, 0, 1, "callret_empty");
    step(0, 0, 2'b11, 0, 0, 0, 5'd12, 1, 0, 0, "ret_pushed12");
    // Stall holds pc and the stack
    for (int i = 0; i < 3; i++)
      step(0, 1, 2'b01, 5'd0, 0, 1, 5'd12, 1, 0, 0, "stall_hold");
    step(0, 0, 2'b00, 0, 0, 1, 5'd16, 0, 0, 0, "push16b");
    for (int i = 0; i < 3; i++)
      step(0, 1, 2'b11, 5'd0, 0, 1, 5'd16, 0, 0, 0, "stall_hold2");
    step(0, 0, 2'b11, 0, 0, 0, 5'd16, 1, 0, 0, "ret_after_stall");
    step(0, 0, 2'b00, 0, 0, 1, 5'd20, 0, 0, 0, "push20b");
    step(1, 1, 2'b01, 5'd7, 0, 1, 5'd0, 1, 0, 0, "rst_in_stall");
    step(0, 0, 2'b11, 0, 0, 0, 5'd4, 1, 0, 1, "ret_after_rst");
    rst = 0; stall = 0; pcsel = 2'b00; call = 0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
